soc_system_gpio_pio: RTL and testbench
======================================

// Module: soc_system_gpio_pio
// PURPOSE
// Parametrised Avalon-MM GPIO for the HPS-FPGA bridge: WIDTH bidirectional pins, per-bit direction,
// input synchroniser, edge capture with per-bit interrupt mask, and atomic set/clear of output bits.
// Drop-in for PIO slots in soc_system where software needs interrupts or read-modify-write-free output.
// PARAMETERS
// WIDTH        32  pin count, 1..32; register bits above WIDTH read 0, writes ignored
// SYNC_STAGES  2   input synchroniser flops, 2..3
// EDGE_TYPE    0   0 rising, 1 falling, 2 any edge
// RESET_VALUE  0   data_out reset value (WIDTH bits)
// RESET_DIR    0   direction reset value, 1 = output
// PORTS
// clk        in   1      clock
// reset_n    in   1      asynchronous, active-low reset
// address    in   3      register word address
// chipselect in   1      slave select
// write_n    in   1      active-low write strobe
// writedata  in   32     write data
// readdata   out  32     registered read data
// in_port    in   WIDTH  pin inputs, asynchronous to clk
// out_port   out  WIDTH  pin output values
// oe         out  WIDTH  pin output enables (= direction)
// irq        out  1      level interrupt, registered
// BEHAVIOUR
// - Register map: 0 DATA, 1 DIRECTION, 2 IRQMASK, 3 EDGECAPTURE, 4 OUTSET, 5 OUTCLEAR; 6,7 read 0, writes ignored.
// - Write when chipselect & ~write_n, takes effect next clk edge.
// - DATA write loads data_out; OUTSET: data_out |= wd; OUTCLEAR: data_out &= ~wd; reads of 4/5 return 0.
// - DATA read: bit i = direction[i] ? data_out[i] : in_sync[i].
// - readdata registered every cycle from address (chipselect ignored): 1-cycle read latency; reset 0.
// - Synchroniser: SYNC_STAGES flops then in_prev flop; all reset to 0.
// - Edge detect on in_sync vs in_prev per EDGE_TYPE, only for input bits (direction=0).
// - Priming: counter suppresses edge detection for SYNC_STAGES+1 cycles after reset release (no false edges).
// - EDGECAPTURE: sticky per bit; write 1 clears bit; same-cycle new edge and clear -> bit stays set.
// - irq = |(edgecapture & irqmask), registered, 1-cycle lag after capture/mask/clear change; reset 0.
// - Reset values: data_out=RESET_VALUE, direction=RESET_DIR, irqmask=0, edgecapture=0, irq=0, readdata=0.
// - Reset mid-operation: all state asynchronously cleared, priming restarts; no pending irq survives.
// - out_port = data_out always (even for input bits); oe = direction.
// - Read of EDGECAPTURE in same cycle as clear write returns pre-clear value.
// STRUCTURE
// - Package gpio_pio_pkg: register address localparams (ADDR_DATA..ADDR_OUTCLEAR), EDGE_RISING/FALLING/ANY constants.
// - Sub-module gpio_pio_edge_detect: synchroniser chain, in_prev, priming counter, per-bit edge pulses.
// - Top: register file, read mux, capture/irq logic.
// TESTING
// - Reset with in_port=32'hFFFF_FFFF, RESET_VALUE=32'hA5 -> out_port=32'hA5, edgecapture stays 0, irq=0.
// - Write DIRECTION=32'h0000_00FF, DATA=32'h1234_5678 -> oe=32'hFF, out_port=32'h1234_5678; DATA read = {in_sync[31:8],8'h78} two cycles later.
// - OUTSET 32'h0F00 then OUTCLEAR 32'h0078 -> out_port=32'h1234_5F00; no other bits disturbed.
// - EDGE_TYPE=0, IRQMASK=32'h1, in_port[0] 0->1 -> EDGECAPTURE=1 after SYNC_STAGES+1 cycles, irq high one cycle later; falling edge no capture.
// - Write EDGECAPTURE=1 in the cycle a new edge lands on bit 0 -> bit remains 1, irq stays high; later clear -> irq low next cycle.
// - Assert reset_n mid-capture with irq high -> irq, edgecapture, readdata 0 immediately; no capture during priming window.

Source files
------------

// File: rtl/gpio_pio_pkg.sv
// ============================================================
// gpio_pio_pkg : register map and edge-type encodings for the
//                soc_system_gpio_pio block
// Revision 1.0
// ============================================================
`default_nettype none

package gpio_pio_pkg;

  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET      = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

`default_nettype wire

// File: rtl/gpio_pio_edge_detect.sv
// ============================================================
// gpio_pio_edge_detect : pin synchroniser, previous-value flop,
//                        priming counter and per-bit edge pulses
// Revision 1.0
// ============================================================
`default_nettype none

module gpio_pio_edge_detect
  import gpio_pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [WIDTH-1:0] direction,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam logic [2:0] c_PRIME_LAST = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [2:0]       r_prime_cnt;
  logic             w_primed;
  logic [WIDTH-1:0] w_edge_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev      <= '0;
      r_prime_cnt <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
      if (!w_primed) r_prime_cnt <= r_prime_cnt + 3'd1;
    end
  end

  assign in_sync = r_sync[SYNC_STAGES-1];
  // The chain fills from zero after reset; hide those transitions until it has settled.
  assign w_primed = (r_prime_cnt == c_PRIME_LAST);

  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_rising
      assign w_edge_raw = in_sync & ~r_prev;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
      assign w_edge_raw = ~in_sync & r_prev;
    end else begin : g_any
      assign w_edge_raw = in_sync ^ r_prev;
    end
  endgenerate

  assign edge_pulse = w_primed ? (w_edge_raw & ~direction) : '0;

endmodule

`default_nettype wire

// File: rtl/soc_system_gpio_pio.sv
// ============================================================
// soc_system_gpio_pio : Avalon-MM GPIO with direction control,
//                       edge capture, irq mask and set/clear
// Revision 1.0
// ============================================================
`default_nettype none

module soc_system_gpio_pio
  import gpio_pio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = EDGE_RISING,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_direction;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic             r_irq;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_cap_clear;
  logic [WIDTH-1:0] w_in_sync;
  logic [WIDTH-1:0] w_edge_pulse;
  logic [WIDTH-1:0] w_data_rd;
  logic [31:0]      w_rd_mux;

  gpio_pio_edge_detect #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_detect (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .direction  (r_direction),
    .in_sync    (w_in_sync),
    .edge_pulse (w_edge_pulse)
  );

  assign w_wr        = chipselect & ~write_n;
  assign w_wdata     = writedata[WIDTH-1:0];
  assign w_cap_clear = (w_wr && (address == ADDR_EDGECAPTURE)) ? w_wdata : '0;
  assign w_data_rd   = (r_direction & r_data_out) | (~r_direction & w_in_sync);

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:        w_rd_mux[WIDTH-1:0] = w_data_rd;
      ADDR_DIRECTION:   w_rd_mux[WIDTH-1:0] = r_direction;
      ADDR_IRQMASK:     w_rd_mux[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAPTURE: w_rd_mux[WIDTH-1:0] = r_edgecap;
      default:          w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out  <= RESET_VALUE[WIDTH-1:0];
      r_direction <= RESET_DIR[WIDTH-1:0];
      r_irqmask   <= '0;
      r_edgecap   <= '0;
      r_irq       <= 1'b0;
      r_readdata  <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          ADDR_DATA:      r_data_out  <= w_wdata;
          ADDR_DIRECTION: r_direction <= w_wdata;
          ADDR_IRQMASK:   r_irqmask   <= w_wdata;
          ADDR_OUTSET:    r_data_out  <= r_data_out | w_wdata;
          ADDR_OUTCLEAR:  r_data_out  <= r_data_out & ~w_wdata;
          default:        ;
        endcase
      end
      // A new edge wins over a simultaneous software clear of the same bit.
      r_edgecap  <= (r_edgecap & ~w_cap_clear) | w_edge_pulse;
      r_irq      <= |(r_edgecap & r_irqmask);
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_data_out;
  assign oe       = r_direction;
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_gpio_pio.sv
// ============================================================
// tb_soc_system_gpio_pio : randomized scoreboard bench for
//                          soc_system_gpio_pio
// Revision 1.0
// ============================================================
`default_nettype none

module tb_soc_system_gpio_pio;

  localparam int          S  = 2;
  localparam logic [31:0] RV = 32'h0000_00A5;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [31:0] in_port    = 32'hFFFF_FFFF;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic [31:0] oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  soc_system_gpio_pio #(
    .WIDTH       (32),
    .SYNC_STAGES (S),
    .EDGE_TYPE   (0),
    .RESET_VALUE (RV),
    .RESET_DIR   (32'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus a delay line of sampled pins.
  logic [31:0] m_data, m_dir, m_mask, m_cap;
  logic        m_irq;
  logic [31:0] hist[$];
  int          m_edges_since_reset;

  typedef struct {logic [2:0] addr; logic [31:0] val;} rd_exp_t;
  rd_exp_t exp_q[$];
  logic    rd_flag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_data = RV; m_dir = '0; m_mask = '0; m_cap = '0; m_irq = 1'b0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(32'h0);
    m_edges_since_reset = 0;
    exp_q.delete();
    rd_flag = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  function automatic void model_step();
    logic [31:0] sync_v, prev_v, edges, rv, clr;
    logic        wr, nirq;
    if (!reset_n) return;
    sync_v = hist[1];
    prev_v = hist[0];
    case (address)
      3'd0:    rv = (m_dir & m_data) | (~m_dir & sync_v);
      3'd1:    rv = m_dir;
      3'd2:    rv = m_mask;
      3'd3:    rv = m_cap;
      default: rv = 32'h0;
    endcase
    if (chipselect && write_n) begin
      exp_q.push_back('{addr: address, val: rv});
      rd_flag = 1'b1;
    end
    edges = (m_edges_since_reset >= S + 1) ? (sync_v & ~prev_v & ~m_dir) : 32'h0;
    nirq  = |(m_cap & m_mask);
    wr    = chipselect && !write_n;
    clr   = (wr && address == 3'd3) ? writedata : 32'h0;
    m_cap = (m_cap & ~clr) | edges;
    if (wr) begin
      case (address)
        3'd0:    m_data = writedata;
        3'd1:    m_dir  = writedata;
        3'd2:    m_mask = writedata;
        3'd4:    m_data = m_data | writedata;
        3'd5:    m_data = m_data & ~writedata;
        default: ;
      endcase
    end
    hist.push_back(in_port);
    void'(hist.pop_front());
    if (m_edges_since_reset < 1000) m_edges_since_reset++;
    m_irq = nirq;
  endfunction

  // Monitor: compares the always-visible outputs and pops read responses.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk("rst_out_port", out_port, RV);
      chk("rst_oe", oe, 32'h0);
    end else begin
      chk("out_port", out_port, m_data);
      chk("oe", oe, m_dir);
      chk("irq", {31'h0, irq}, {31'h0, m_irq});
      if (rd_flag) begin
        rd_flag = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL readdata: got %h expected none queued", readdata);
        end else begin
          rd_exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("readdata[a%0d]", e.addr), readdata, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    model_reset();
    idle(3);
    reset_n = 1'b1;
    // Pins held high through reset release: priming must hide the fill-up edge.
    wr(3'd2, 32'hFFFF_FFFF);
    idle(5);
    rd(3'd3);
    rd(3'd0);
    wr(3'd2, 32'h0);

    in_port = 32'hCAFE_BEEF;
    wr(3'd1, 32'h0000_00FF);
    wr(3'd0, 32'h1234_5678);
    idle(2);
    rd(3'd0);
    rd(3'd1);
    wr(3'd4, 32'h0000_0F00);
    wr(3'd5, 32'h0000_0078);
    rd(3'd4);
    rd(3'd5);
    rd(3'd0);

    // Rising edge on bit 0 with mask, then falling edge (no capture).
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h1);
    in_port = 32'h0;
    idle(5);
    wr(3'd3, 32'hFFFF_FFFF);
    in_port = 32'h1;
    idle(5);
    rd(3'd3);
    in_port = 32'h0;
    idle(5);
    rd(3'd3);
    // New edge lands in the same cycle as the clear write.
    in_port = 32'h1;
    idle(2);
    wr(3'd3, 32'h1);
    idle(2);
    rd(3'd3);
    wr(3'd3, 32'h1);
    idle(2);
    rd(3'd3);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) in_port = $urandom();
      case ($urandom_range(0, 3))
        0:       tick();
        1:       wr(3'($urandom_range(0, 7)), $urandom());
        default: rd(3'($urandom_range(0, 7)));
      endcase
    end

    // Reset while irq is pending.
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h1);
    wr(3'd3, 32'hFFFF_FFFF);
    in_port = 32'h0;
    idle(4);
    in_port = 32'h1;
    idle(5);
    rd(3'd3);
    reset_n = 1'b0;
    model_reset();
    in_port = 32'hFFFF_FFFF;
    idle(3);
    reset_n = 1'b1;
    wr(3'd2, 32'hFFFF_FFFF);
    idle(6);
    rd(3'd3);
    rd(3'd2);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
